// File: rtl/uart_fifo_ctrl.sv
// UART controller: 16x baud tick, TX/RX engines with optional parity, TX and RX
// FIFOs, sticky error flags and an echo path from RX into the TX FIFO.

module uart_fifo_ctrl_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (cnt_q == DEPTH);
    assign empty_o   = (cnt_q == '0);
    assign pop_ok_s  = pop_i && !empty_o;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign push_ok_s = push_i && (!full_o || pop_ok_s);
    assign rdata_o   = mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok_s) begin
            wr_d = wr_q + 1'b1;
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + 1'b1;
        end else begin
            rd_d = rd_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop_ok_s && !push_ok_s) begin
            cnt_d = cnt_q - 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= wdata_i;
        end
    end
endmodule

module uart_fifo_ctrl #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int DATA_W     = 8,
    parameter int FIFO_AW    = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              tx,
    input  logic              echo_en,
    input  logic              tx_wr,
    input  logic [DATA_W-1:0] tx_wdata,
    output logic              tx_full,
    output logic              tx_empty,
    output logic              tx_busy,
    output logic              tx_done,
    input  logic              rx_rd,
    output logic [DATA_W-1:0] rx_rdata,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              rx_done,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun,
    input  logic              err_clr
);
    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam int BCW     = $clog2(DATA_W);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_W - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    function automatic logic par_fn(input logic [DATA_W-1:0] d);
        par_fn = (^d) ^ (PARITY_ODD != 0);
    endfunction

    logic [DCW-1:0]    baud_cnt_q, baud_cnt_d;
    logic              tick_s;

    logic              tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
    logic [DATA_W-1:0] tx_push_data_s, tx_head_s;
    logic              rx_push_s, rx_full_s, rx_empty_s;

    logic [2:0]        tx_state_q, tx_state_d;
    logic [3:0]        tx_tcnt_q, tx_tcnt_d;
    logic [BCW-1:0]    tx_bcnt_q, tx_bcnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic              tx_par_q, tx_par_d, tx_q, tx_d, tx_done_q, tx_done_d, tx_busy_q;

    logic              rx_m_q, rx_s_q;
    logic [2:0]        rx_state_q, rx_state_d;
    logic [3:0]        rx_tcnt_q, rx_tcnt_d;
    logic [BCW-1:0]    rx_bcnt_q, rx_bcnt_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic              rx_par_q, rx_par_d, rx_end_s;
    logic              rx_par_ok_s, rx_good_s, dest_blocked_s;
    logic              rx_done_q, frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic              overrun_q, overrun_d;

    assign tick_s     = (baud_cnt_q == DIV_LAST);
    assign baud_cnt_d = tick_s ? '0 : baud_cnt_q + 1'b1;

    // Echo mode steals the TX FIFO write port from the user.
    assign tx_push_s      = echo_en ? rx_good_s : tx_wr;
    assign tx_push_data_s = echo_en ? rx_sh_q : tx_wdata;
    assign rx_push_s      = rx_good_s && !echo_en;

    uart_fifo_ctrl_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push_i(tx_push_s), .wdata_i(tx_push_data_s),
        .pop_i(tx_pop_s), .rdata_o(tx_head_s), .full_o(tx_full_s), .empty_o(tx_empty_s)
    );

    uart_fifo_ctrl_fifo #(.DW(DATA_W), .AW(FIFO_AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push_i(rx_push_s), .wdata_i(rx_sh_q),
        .pop_i(rx_rd), .rdata_o(rx_rdata), .full_o(rx_full_s), .empty_o(rx_empty_s)
    );

    // TX engine; a queued byte starts straight from the last stop tick so frames abut.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_done_d  = 1'b0;
        tx_pop_s   = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (tick_s && !tx_empty_s) begin
                    tx_pop_s   = 1'b1;
                    tx_sh_d    = tx_head_s;
                    tx_par_d   = par_fn(tx_head_s);
                    tx_d       = 1'b0;
                    tx_tcnt_d  = 4'd0;
                    tx_state_d = S_START;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            S_START, S_DATA, S_PARITY, S_STOP: begin
                if (tick_s && tx_tcnt_q != 4'd15) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                end else if (tick_s) begin
                    tx_tcnt_d = 4'd0;
                    if (tx_state_q == S_START) begin
                        tx_bcnt_d  = '0;
                        tx_d       = tx_sh_q[0];
                        tx_state_d = S_DATA;
                    end else if (tx_state_q == S_DATA && tx_bcnt_q != BIT_LAST) begin
                        tx_bcnt_d = tx_bcnt_q + 1'b1;
                        tx_sh_d   = {1'b0, tx_sh_q[DATA_W-1:1]};
                        tx_d      = tx_sh_q[1];
                    end else if (tx_state_q == S_DATA && PARITY_EN != 0) begin
                        tx_d       = tx_par_q;
                        tx_state_d = S_PARITY;
                    end else if (tx_state_q != S_STOP) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else if (!tx_empty_s) begin
                        tx_done_d  = 1'b1;
                        tx_pop_s   = 1'b1;
                        tx_sh_d    = tx_head_s;
                        tx_par_d   = par_fn(tx_head_s);
                        tx_d       = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_done_d  = 1'b1;
                        tx_d       = 1'b1;
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_tcnt_d = tx_tcnt_q;
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = S_IDLE;
            end
        endcase
    end

    // RX engine: sample mid-bit, leave at mid-stop so the next start edge is caught.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bcnt_d  = rx_bcnt_q;
        rx_sh_d    = rx_sh_q;
        rx_par_d   = rx_par_q;
        rx_end_s   = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    rx_tcnt_d  = 4'd0;
                    rx_state_d = S_START;
                end else begin
                    rx_state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s && rx_tcnt_q == 4'd7) begin
                    rx_tcnt_d  = 4'd0;
                    rx_bcnt_d  = '0;
                    rx_state_d = rx_s_q ? S_IDLE : S_DATA;
                end else if (tick_s) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                end else begin
                    rx_tcnt_d = rx_tcnt_q;
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (tick_s && rx_tcnt_q == 4'd15) begin
                    rx_tcnt_d = 4'd0;
                    if (rx_state_q == S_DATA) begin
                        rx_sh_d = {rx_s_q, rx_sh_q[DATA_W-1:1]};
                        if (rx_bcnt_q != BIT_LAST) begin
                            rx_bcnt_d = rx_bcnt_q + 1'b1;
                        end else begin
                            rx_state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end else if (rx_state_q == S_PARITY) begin
                        rx_par_d   = rx_s_q;
                        rx_state_d = S_STOP;
                    end else begin
                        rx_end_s   = 1'b1;
                        rx_state_d = S_IDLE;
                    end
                end else if (tick_s) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                end else begin
                    rx_tcnt_d = rx_tcnt_q;
                end
            end
            default: begin
                rx_state_d = S_IDLE;
            end
        endcase
    end

    assign rx_par_ok_s    = (PARITY_EN == 0) || (rx_par_q == par_fn(rx_sh_q));
    assign rx_good_s      = rx_end_s && rx_s_q && rx_par_ok_s;
    assign dest_blocked_s = echo_en ? (tx_full_s && !tx_pop_s)
                                    : (rx_full_s && !(rx_rd && !rx_empty_s));
    // Sticky flags: a new event in the clear cycle keeps the flag set.
    assign frame_err_d  = (frame_err_q && !err_clr) || (rx_end_s && !rx_s_q);
    assign parity_err_d = (parity_err_q && !err_clr) || (rx_end_s && !rx_par_ok_s);
    assign overrun_d    = (overrun_q && !err_clr) || (rx_good_s && dest_blocked_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt_q   <= '0;
            tx_state_q   <= S_IDLE;
            tx_tcnt_q    <= 4'd0;
            tx_bcnt_q    <= '0;
            tx_sh_q      <= '0;
            tx_par_q     <= 1'b0;
            tx_q         <= 1'b1;
            tx_done_q    <= 1'b0;
            tx_busy_q    <= 1'b0;
            rx_m_q       <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_state_q   <= S_IDLE;
            rx_tcnt_q    <= 4'd0;
            rx_bcnt_q    <= '0;
            rx_sh_q      <= '0;
            rx_par_q     <= 1'b0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            baud_cnt_q   <= baud_cnt_d;
            tx_state_q   <= tx_state_d;
            tx_tcnt_q    <= tx_tcnt_d;
            tx_bcnt_q    <= tx_bcnt_d;
            tx_sh_q      <= tx_sh_d;
            tx_par_q     <= tx_par_d;
            tx_q         <= tx_d;
            tx_done_q    <= tx_done_d;
            tx_busy_q    <= (tx_state_d != S_IDLE);
            rx_m_q       <= rx;
            rx_s_q       <= rx_m_q;
            rx_state_q   <= rx_state_d;
            rx_tcnt_q    <= rx_tcnt_d;
            rx_bcnt_q    <= rx_bcnt_d;
            rx_sh_q      <= rx_sh_d;
            rx_par_q     <= rx_par_d;
            rx_done_q    <= rx_end_s;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign tx         = tx_q;
    assign tx_full    = tx_full_s;
    assign tx_empty   = tx_empty_s;
    assign tx_busy    = tx_busy_q;
    assign tx_done    = tx_done_q;
    assign rx_empty   = rx_empty_s;
    assign rx_full    = rx_full_s;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Scoreboard bench: serial frames are decoded by monitors and compared against
// queues filled by the stimulus from a byte-level model of the UART.
module tb_uart_fifo_ctrl;
    localparam int BIT_CLK = 160;

    logic clk = 1'b0;
    logic rst, rx, echo_en, tx_wr, rx_rd, err_clr;
    logic [7:0] tx_wdata, rx_rdata;
    logic tx, tx_full, tx_empty, tx_busy, tx_done, rx_empty, rx_full, rx_done;
    logic frame_err, parity_err, overrun;

    logic rxp;
    logic [7:0] rxp_rdata;
    logic txp, tx_full_p, tx_empty_p, tx_busy_p, tx_done_p, rxp_empty, rx_full_p, rx_done_p;
    logic frame_err_p, parity_err_p, overrun_p;

    int n_checks = 0, n_fail = 0, cyc = 0;
    int rx_done_seen = 0, tx_done_seen = 0, rx_done_exp = 0, tx_done_exp = 0;
    logic m_fe = 1'b0, m_pe = 1'b0, m_ov = 1'b0, mp_pe = 1'b0;
    logic tx_mon_en = 1'b0, rx_drain_en = 1'b0;
    logic [7:0] exp_tx_q[$], exp_rx_q[$];
    int tx_starts[$];

    always #5 clk = ~clk;

    uart_fifo_ctrl #(.CLK_FREQ(1_600_000), .BAUD(10000), .DATA_W(8), .FIFO_AW(4),
                     .PARITY_EN(0), .PARITY_ODD(0)) dut (
        .clk(clk), .rst(rst), .rx(rx), .tx(tx), .echo_en(echo_en), .tx_wr(tx_wr),
        .tx_wdata(tx_wdata), .tx_full(tx_full), .tx_empty(tx_empty), .tx_busy(tx_busy),
        .tx_done(tx_done), .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_done(rx_done), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun), .err_clr(err_clr)
    );

    uart_fifo_ctrl #(.CLK_FREQ(1_600_000), .BAUD(10000), .DATA_W(8), .FIFO_AW(4),
                     .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk(clk), .rst(rst), .rx(rxp), .tx(txp), .echo_en(1'b0), .tx_wr(1'b0),
        .tx_wdata(8'h00), .tx_full(tx_full_p), .tx_empty(tx_empty_p), .tx_busy(tx_busy_p),
        .tx_done(tx_done_p), .rx_rd(1'b0), .rx_rdata(rxp_rdata), .rx_empty(rxp_empty),
        .rx_full(rx_full_p), .rx_done(rx_done_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun(overrun_p), .err_clr(1'b0)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_done) rx_done_seen <= rx_done_seen + 1;
        if (tx_done) tx_done_seen <= tx_done_seen + 1;
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // TX line decoder: mid-bit sampling, compares against the expected byte queue.
    initial begin
        logic prev;
        logic [7:0] d;
        logic [7:0] e;
        int t0;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (tx_mon_en && prev && !tx) begin
                t0 = cyc;
                repeat (BIT_CLK/2 - 1) @(negedge clk);
                check("tx_start_bit", tx, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CLK) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT_CLK) @(negedge clk);
                check("tx_stop_bit", tx, 1);
                tx_starts.push_back(t0);
                if (exp_tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got byte 0x%02h, none expected", d);
                end else begin
                    e = exp_tx_q.pop_front();
                    check("tx_byte", d, e);
                end
            end
            prev = tx;
        end
    end

    // RX FIFO drain: pops whenever data is presented and draining is enabled.
    initial begin
        logic [7:0] e;
        rx_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_drain_en && rst && !rx_empty) begin
                if (exp_rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte 0x%02h, none expected", rx_rdata);
                end else begin
                    e = exp_rx_q.pop_front();
                    check("rx_byte", rx_rdata, e);
                end
                rx_rd = 1'b1;
                @(negedge clk);
                rx_rd = 1'b0;
            end
        end
    end

    task automatic drive_rx(input int which, input logic b);
        if (which == 0) rx = b;
        else rxp = b;
    endtask

    // Drive one frame; the outcome is predicted before the stop bit so it is queued
    // ahead of the DUT's mid-stop push.
    task automatic send_frame(input int which, input logic [7:0] data, input logic par_bit,
                              input logic stop_bit);
        logic pen, par_ok, good;
        pen = (which == 1);
        drive_rx(which, 1'b0);
        repeat (BIT_CLK) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive_rx(which, data[i]);
            repeat (BIT_CLK) @(negedge clk);
        end
        if (pen) begin
            drive_rx(which, par_bit);
            repeat (BIT_CLK) @(negedge clk);
        end
        par_ok = !pen || (par_bit == ^data);
        good = stop_bit && par_ok;
        if (which == 0) begin
            rx_done_exp++;
            if (!stop_bit) m_fe = 1'b1;
            if (good && echo_en) begin
                exp_tx_q.push_back(data);
                tx_done_exp++;
            end else if (good && exp_rx_q.size() >= 16) begin
                m_ov = 1'b1;
            end else if (good) begin
                exp_rx_q.push_back(data);
            end
        end else if (!par_ok) begin
            mp_pe = 1'b1;
        end
        drive_rx(which, stop_bit);
        repeat (100) @(negedge clk);
        drive_rx(which, 1'b1);
        repeat (BIT_CLK - 100) @(negedge clk);
    endtask

    task automatic write_tx(input logic [7:0] b);
        tx_wr = 1'b1;
        tx_wdata = b;
        @(negedge clk);
        tx_wr = 1'b0;
    endtask

    task automatic wait_tx_drain(input int limit, input string nm);
        int n;
        n = 0;
        while (exp_tx_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(nm, exp_tx_q.size(), 0);
    endtask

    task automatic wait_rx_drain(input int limit, input string nm);
        int n;
        n = 0;
        while ((exp_rx_q.size() != 0 || !rx_empty) && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(nm, exp_rx_q.size(), 0);
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        m_fe = 1'b0;
        m_pe = 1'b0;
        m_ov = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int m_occ;
        rst = 1'b0;
        rx = 1'b1;
        rxp = 1'b1;
        echo_en = 1'b0;
        tx_wr = 1'b0;
        tx_wdata = 8'h00;
        err_clr = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_tx_empty", tx_empty, 1);
        check("rst_rx_empty", rx_empty, 1);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_flags", {frame_err, parity_err, overrun}, 0);
        rst = 1'b1;
        tx_mon_en = 1'b1;
        rx_drain_en = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte out of the TX side
        exp_tx_q.push_back(8'h55);
        tx_done_exp++;
        write_tx(8'h55);
        wait_tx_drain(3000, "tx_single_timeout");
        repeat (120) @(negedge clk);
        check("tx_done_count1", tx_done_seen, tx_done_exp);
        check("tx_busy_after", tx_busy, 0);
        check("tx_empty_after", tx_empty, 1);

        // Single RX frame
        send_frame(0, 8'hA3, 1'b0, 1'b1);
        wait_rx_drain(500, "rx_single_timeout");
        check("rx_done_count1", rx_done_seen, rx_done_exp);
        check("rx_empty_after_rd", rx_empty, 1);

        // TX burst while the engine is busy: 16 accepted, 17th dropped
        tx_starts.delete();
        b = 8'($urandom_range(0, 255));
        exp_tx_q.push_back(b);
        tx_done_exp++;
        write_tx(b);
        repeat (20) @(negedge clk);
        m_occ = 0;
        for (int i = 0; i < 17; i++) begin
            b = 8'($urandom_range(0, 255));
            tx_wr = 1'b1;
            tx_wdata = b;
            @(negedge clk);
            if (m_occ < 16) begin
                exp_tx_q.push_back(b);
                tx_done_exp++;
                m_occ++;
            end
            check("tx_full_burst", tx_full, (m_occ == 16) ? 1 : 0);
        end
        tx_wr = 1'b0;
        wait_tx_drain(30000, "tx_burst_timeout");
        check("burst_frames", tx_starts.size(), 17);
        for (int i = 1; i < tx_starts.size(); i++)
            check("burst_gap", tx_starts[i] - tx_starts[i-1], 10 * BIT_CLK);
        repeat (120) @(negedge clk);
        check("tx_done_count2", tx_done_seen, tx_done_exp);
        check("tx_busy_idle", tx_busy, 0);

        // 17 RX frames without reading: overrun on the last
        rx_drain_en = 1'b0;
        for (int i = 0; i < 17; i++) send_frame(0, 8'($urandom_range(0, 255)), 1'b0, 1'b1);
        check("rx_full_ovr", rx_full, 1);
        check("overrun_set", overrun, m_ov);
        check("rx_done_count2", rx_done_seen, rx_done_exp);
        repeat (300) @(negedge clk);
        check("overrun_sticky", overrun, m_ov);
        pulse_err_clr();
        check("overrun_clr", overrun, m_ov);
        rx_drain_en = 1'b1;
        wait_rx_drain(2000, "rx_burst_timeout");
        check("rx_empty_burst", rx_empty, 1);

        // Parity instance: bad then good parity for 0x07
        send_frame(1, 8'h07, 1'b0, 1'b1);
        check("p_parity_err", parity_err_p, mp_pe);
        check("p_rx_empty_bad", rxp_empty, 1);
        send_frame(1, 8'h07, 1'b1, 1'b1);
        check("p_rx_empty_good", rxp_empty, 0);
        check("p_rdata", rxp_rdata, 8'h07);
        check("p_frame_err", frame_err_p, 0);

        // Short low glitch is rejected silently
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        repeat (300) @(negedge clk);
        check("glitch_rx_done", rx_done_seen, rx_done_exp);
        check("glitch_flags", {frame_err, parity_err, overrun}, {m_fe, m_pe, m_ov});

        // Bad stop bit
        send_frame(0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
        check("frame_err_set", frame_err, m_fe);
        check("frame_err_rx_done", rx_done_seen, rx_done_exp);
        check("frame_err_discard", rx_empty, 1);
        pulse_err_clr();
        check("frame_err_clr", frame_err, m_fe);

        // Echo loop
        echo_en = 1'b1;
        send_frame(0, 8'h3C, 1'b0, 1'b1);
        wait_tx_drain(3000, "echo_timeout");
        echo_en = 1'b0;
        repeat (120) @(negedge clk);
        check("echo_tx_done", tx_done_seen, tx_done_exp);
        check("echo_rx_empty", rx_empty, 1);

        // Reset mid-frame forces the line idle asynchronously
        tx_mon_en = 1'b0;
        repeat (10) @(negedge clk);
        write_tx(8'h00);
        repeat (400) @(negedge clk);
        check("pre_rst_tx_low", tx, 0);
        rst = 1'b0;
        #1;
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", tx_busy, 0);
        check("rst_mid_empty", tx_empty, 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
